// File: rtl/cross_pkg.sv
// Shared types, constants and arithmetic helpers for the cross-product inverter.
package cross_pkg;
  typedef logic signed [7:0]  comp_t;
  typedef logic signed [15:0] prod_t;

  typedef enum logic [2:0] {IDLE, DIV_C, DIV_D, CHECK, DONE} state_t;

  localparam int DIV_ITER = 16;
  localparam int LATENCY  = 34;

  typedef struct packed {
    comp_t value;
    logic  inexact;
    logic  range;
  } quo_res_t;

  function automatic logic [16:0] mag_prod(input prod_t x);
    logic [16:0] e;
    e = {x[15], x};
    return x[15] ? 17'(17'd0 - e) : e;
  endfunction

  function automatic logic [7:0] mag_comp(input comp_t x);
    logic [7:0] u;
    u = x;
    return x[7] ? 8'(8'd0 - u) : u;
  endfunction

  // Applies the sign, saturates to -128..127 and suppresses flags on a zero divisor.
  function automatic quo_res_t finish_quo(input logic [16:0] mag, input logic [7:0] rem,
                                          input logic neg, input logic div_zero);
    quo_res_t r;
    r.value   = '0;
    r.inexact = 1'b0;
    r.range   = 1'b0;
    if (!div_zero) begin
      r.inexact = (rem != 8'd0);
      if (neg) begin
        if (mag > 17'd128) begin
          r.value = comp_t'(8'h80);
          r.range = 1'b1;
        end else begin
          r.value = comp_t'(8'(8'd0 - mag[7:0]));
        end
      end else if (mag > 17'd127) begin
        r.value = comp_t'(8'h7F);
        r.range = 1'b1;
      end else begin
        r.value = comp_t'(mag[7:0]);
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/seq_div.sv
// Serial restoring divider, 17-bit / 8-bit magnitudes, one quotient bit per cycle.
// Bit 16 is resolved at load; o_done marks the final iteration and o_quo/o_rem carry its result.
module seq_div
  import cross_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic [16:0] i_dividend,
  input  logic [7:0]  i_divisor,
  output logic        o_done,
  output logic [16:0] o_quo,
  output logic [7:0]  o_rem
);
  logic [16:0] r_work;
  logic [7:0]  r_rem;
  logic [7:0]  r_div;
  logic [3:0]  r_cnt;
  logic        r_busy;

  logic [8:0]  w_trial;
  logic        w_q;
  logic [7:0]  w_rem_nxt;
  logic [8:0]  w_ld_trial;
  logic        w_ld_q;
  logic [7:0]  w_ld_rem;

  always_comb begin
    w_trial    = {r_rem, r_work[16]};
    w_q        = (w_trial >= {1'b0, r_div});
    w_rem_nxt  = w_q ? 8'(w_trial - {1'b0, r_div}) : w_trial[7:0];
    w_ld_trial = {8'd0, i_dividend[16]};
    w_ld_q     = (w_ld_trial >= {1'b0, i_divisor});
    w_ld_rem   = w_ld_q ? 8'(w_ld_trial - {1'b0, i_divisor}) : w_ld_trial[7:0];
  end

  // r_work shifts remaining dividend bits out of the top and quotient bits in at the bottom.
  assign o_done = r_busy && (r_cnt == 4'(DIV_ITER - 1));
  assign o_quo  = {r_work[15:0], w_q};
  assign o_rem  = w_rem_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_work <= '0;
      r_rem  <= '0;
      r_div  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (i_start) begin
      r_work <= {i_dividend[15:0], w_ld_q};
      r_rem  <= w_ld_rem;
      r_div  <= i_divisor;
      r_cnt  <= '0;
      r_busy <= 1'b1;
    end else if (r_busy) begin
      r_work <= o_quo;
      r_rem  <= w_rem_nxt;
      r_cnt  <= r_cnt + 4'd1;
      if (o_done) r_busy <= 1'b0;
    end
  end
endmodule

// File: rtl/cross_inverse.sv
// Recovers V2 = V21 j + V22 k from V1 = V11 i + V12 j and the cross product V1 x V2.
// Handshake: a transfer happens on a rising edge where valid and ready are both 1.
module cross_inverse
  import cross_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  comp_t       V11,
  input  comp_t       V12,
  input  prod_t       Vo1,
  input  prod_t       Vo2,
  input  prod_t       Vo3,
  output logic        out_valid,
  input  logic        out_ready,
  output comp_t       V21,
  output comp_t       V22,
  output logic [1:0]  err_zero,
  output logic        err_inexact,
  output logic        err_range,
  output logic        err_mismatch,
  output state_t      o_dbg_state
);
  state_t      r_state, w_state_nxt;
  comp_t       r_v11, r_v12, r_v21, r_v22;
  prod_t       r_vo1, r_vo2;
  logic        r_vo3_neg;
  logic [1:0]  r_err_zero;
  logic        r_err_inexact, r_err_range, r_err_mismatch;

  logic        w_div_start, w_div_done;
  logic [16:0] w_dividend, w_quo;
  logic [7:0]  w_divisor, w_rem;
  quo_res_t    w_res;
  prod_t       w_prod, w_neg_prod;

  // The first division loads straight from the ports on the accept edge; the second
  // reloads the shared divider on the edge that retires the first.
  always_comb begin
    w_div_start = 1'b0;
    w_dividend  = '0;
    w_divisor   = '0;
    if (r_state == IDLE && in_valid) begin
      w_div_start = 1'b1;
      w_dividend  = mag_prod(Vo3);
      w_divisor   = mag_comp(V11);
    end else if (r_state == DIV_C && w_div_done) begin
      w_div_start = 1'b1;
      w_dividend  = mag_prod(r_vo1);
      w_divisor   = mag_comp(r_v12);
    end
  end

  seq_div u_div (
    .clk        (clk),
    .rst        (rst),
    .i_start    (w_div_start),
    .i_dividend (w_dividend),
    .i_divisor  (w_divisor),
    .o_done     (w_div_done),
    .o_quo      (w_quo),
    .o_rem      (w_rem)
  );

  always_comb begin
    w_res      = '0;
    if (r_state == DIV_C)
      w_res = finish_quo(w_quo, w_rem, r_vo3_neg ^ r_v11[7], r_v11 == '0);
    else if (r_state == DIV_D)
      w_res = finish_quo(w_quo, w_rem, r_vo1[15] ^ r_v12[7], r_v12 == '0);
    w_prod     = prod_t'(r_v11) * prod_t'(r_v22);
    w_neg_prod = prod_t'(16'sd0 - w_prod);
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (in_valid)   w_state_nxt = DIV_C;
      DIV_C:   if (w_div_done) w_state_nxt = DIV_D;
      DIV_D:   if (w_div_done) w_state_nxt = CHECK;
      CHECK:                   w_state_nxt = DONE;
      DONE:    if (out_ready)  w_state_nxt = IDLE;
      default:                 w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v11 <= '0; r_v12 <= '0; r_vo1 <= '0; r_vo2 <= '0; r_vo3_neg <= 1'b0;
      r_v21 <= '0; r_v22 <= '0;
      r_err_zero <= '0; r_err_inexact <= 1'b0; r_err_range <= 1'b0; r_err_mismatch <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_v11 <= V11; r_v12 <= V12; r_vo1 <= Vo1; r_vo2 <= Vo2; r_vo3_neg <= Vo3[15];
          r_err_zero <= '0; r_err_inexact <= 1'b0; r_err_range <= 1'b0; r_err_mismatch <= 1'b0;
        end
        DIV_C: if (w_div_done) begin
          r_v21         <= w_res.value;
          r_err_zero[0] <= (r_v11 == '0);
          r_err_inexact <= r_err_inexact | w_res.inexact;
          r_err_range   <= r_err_range | w_res.range;
        end
        DIV_D: if (w_div_done) begin
          r_v22         <= w_res.value;
          r_err_zero[1] <= (r_v12 == '0);
          r_err_inexact <= r_err_inexact | w_res.inexact;
          r_err_range   <= r_err_range | w_res.range;
        end
        CHECK: r_err_mismatch <= !r_err_zero[1] && (w_neg_prod != r_vo2);
        default: ;
      endcase
    end
  end

  assign in_ready     = (r_state == IDLE);
  assign out_valid    = (r_state == DONE);
  assign V21          = r_v21;
  assign V22          = r_v22;
  assign err_zero     = r_err_zero;
  assign err_inexact  = r_err_inexact;
  assign err_range    = r_err_range;
  assign err_mismatch = r_err_mismatch;
  assign o_dbg_state  = r_state;
endmodule

// File: tb/tb_cross_inverse.sv
// Directed and random requests checked against an integer-arithmetic model of the inversion.
module tb_cross_inverse;
  import cross_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  comp_t       v11, v12, v21, v22;
  prod_t       vo1, vo2, vo3;
  logic [1:0]  err_zero;
  logic        err_inexact, err_range, err_mismatch;
  state_t      dbg_state;

  int total = 0;
  int bad   = 0;
  logic [20:0] exp_q[$];

  cross_inverse dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .V11(v11), .V12(v12), .Vo1(vo1), .Vo2(vo2), .Vo3(vo3),
    .out_valid(out_valid), .out_ready(out_ready), .V21(v21), .V22(v22),
    .err_zero(err_zero), .err_inexact(err_inexact), .err_range(err_range),
    .err_mismatch(err_mismatch), .o_dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Packed as {V21, V22, err_zero, err_inexact, err_range, err_mismatch}.
  function automatic logic [20:0] model(input int a, input int b, input int o1, input int o2, input int o3);
    int q21 = 0, q22 = 0;
    bit ez0 = 0, ez1 = 0, inx = 0, rng = 0, mm = 0;
    if (a == 0) ez0 = 1;
    else begin
      q21 = o3 / a;
      if (o3 % a != 0) inx = 1;
      if (q21 > 127)  begin q21 = 127;  rng = 1; end
      if (q21 < -128) begin q21 = -128; rng = 1; end
    end
    if (b == 0) ez1 = 1;
    else begin
      q22 = o1 / b;
      if (o1 % b != 0) inx = 1;
      if (q22 > 127)  begin q22 = 127;  rng = 1; end
      if (q22 < -128) begin q22 = -128; rng = 1; end
    end
    mm = !ez1 && (-(a * q22) != o2);
    return {8'(q21), 8'(q22), ez1, ez0, inx, rng, mm};
  endfunction

  function automatic logic [20:0] observed();
    return {v21, v22, err_zero, err_inexact, err_range, err_mismatch};
  endfunction

  task automatic scramble();
    in_valid = 1'($urandom_range(0, 1));
    v11 = 8'($urandom); v12 = 8'($urandom);
    vo1 = 16'($urandom); vo2 = 16'($urandom); vo3 = 16'($urandom);
  endtask

  task automatic drive(input int a, input int b, input int o1, input int o2, input int o3);
    in_valid = 1'b1;
    v11 = 8'(a); v12 = 8'(b);
    vo1 = 16'(o1); vo2 = 16'(o2); vo3 = 16'(o3);
  endtask

  // Called at a falling edge while idle; returns at a falling edge with the block idle again.
  task automatic run_req(input int a, input int b, input int o1, input int o2, input int o3, input int hold);
    int n;
    logic [20:0] exp;
    exp_q.push_back(model(a, b, o1, o2, o3));
    check("in_ready_before_req", {31'd0, in_ready}, 32'd1);
    drive(a, b, o1, o2, o3);
    @(negedge clk);
    n = 1;
    scramble();
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
      if (!out_valid) scramble();
    end
    in_valid = 1'b0;
    check("latency", n, 32'd34);
    exp = exp_q.pop_front();
    check("result", {11'd0, observed()}, {11'd0, exp});
    check("in_ready_busy", {31'd0, in_ready}, 32'd0);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check("hold_valid_ready", {30'd0, out_valid, in_ready}, 32'd2);
      check("hold_result", {11'd0, observed()}, {11'd0, exp});
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("release_idle", {30'd0, out_valid, in_ready}, 32'd1);
  endtask

  task automatic run_abort(input int a, input int b, input int o1, input int o2, input int o3, input int at_n);
    int seen = 0;
    check("in_ready_before_abort", {31'd0, in_ready}, 32'd1);
    drive(a, b, o1, o2, o3);
    @(negedge clk);
    in_valid = 1'b0;
    for (int n = 1; n < at_n; n++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_outputs", {9'd0, in_ready, out_valid, observed()}, {9'd0, 1'b1, 1'b0, 21'd0});
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("abort_no_valid", seen, 32'd0);
  endtask

  initial begin
    int a, b, r21, r22, o1, o2, o3;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    v11 = '0; v12 = '0; vo1 = '0; vo2 = '0; vo3 = '0;
    repeat (2) @(negedge clk);
    check("reset_state", {9'd0, in_ready, out_valid, observed()}, {9'd0, 1'b1, 1'b0, 21'd0});
    rst = 1'b0;

    run_req(2, -5, 10, 4, -24, 0);
    run_abort(3, 4, 9, 0, 10, 24);
    run_req(2, 0, 0, 0, 6, 0);
    run_req(3, 4, 9, 0, 10, 0);
    run_req(-1, 1, 0, 0, -32768, 0);
    run_req(1, 1, 0, 0, 200, 10);
    run_req(-128, -128, -32768, 5, -32768, 1);
    run_req(0, 0, 123, -7, -999, 0);
    run_req(-7, 3, -20, -100, 22, 2);

    for (int i = 0; i < 24; i++) begin
      a = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255)) - 128;
      b = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255)) - 128;
      if ($urandom_range(0, 1) == 1) begin
        r21 = int'($urandom_range(0, 255)) - 128;
        r22 = int'($urandom_range(0, 255)) - 128;
        o1 = b * r22; o2 = -(a * r22); o3 = a * r21;
      end else begin
        o1 = int'($urandom_range(0, 65535)) - 32768;
        o2 = int'($urandom_range(0, 65535)) - 32768;
        o3 = int'($urandom_range(0, 65535)) - 32768;
      end
      run_req(a, b, o1, o2, o3, int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
